// File: rtl/disp_arb_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
package disp_arb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [NUM_REQ-1:0] GNT_NONE  = 3'b000;
    localparam logic [NUM_REQ-1:0] GNT_ENTRY = 3'b001;
    localparam logic [NUM_REQ-1:0] GNT_COUNT = 3'b010;
    localparam logic [NUM_REQ-1:0] GNT_ALERT = 3'b100;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    // [3] = digit_3 ... [0] = digit_0
    typedef logic [3:0][3:0] digits_t;

    function automatic logic [NUM_REQ-1:0] highest_req(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] g;
        g = GNT_NONE;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Bits strictly above the one-hot owner.
    function automatic logic [NUM_REQ-1:0] higher_mask(input logic [NUM_REQ-1:0] owner);
        logic [NUM_REQ-1:0] m;
        logic               seen;
        m    = '0;
        seen = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            m[i] = seen;
            if (owner[i]) begin
                seen = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/display_arbiter_tick_down_counter.sv
// Loadable down-counter stepped by a strobe; stops at zero and flags it.
module tick_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority, minimum-hold arbiter sharing the 4-digit display between three requesters.
// Optional blinking of the alert owner's enables: define DISPLAY_ARB_BLINK_EN.
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int MIN_HOLD_TICKS   = 500,
    parameter int BLINK_HALF_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_ms,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [15:0]         req_0_digits,
    input  logic [15:0]         req_1_digits,
    input  logic [15:0]         req_2_digits,
    input  logic [3:0]          req_0_en,
    input  logic [3:0]          req_1_en,
    input  logic [3:0]          req_2_en,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_changed,
    output logic [3:0]          digit_3,
    output logic [3:0]          digit_2,
    output logic [3:0]          digit_1,
    output logic [3:0]          digit_0,
    output logic                enable_3,
    output logic                enable_2,
    output logic                enable_1,
    output logic                enable_0
);

    localparam int HOLD_W = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;

    if (BLINK_HALF_TICKS < 1) begin : g_bad_blink_half
        $error("BLINK_HALF_TICKS must be at least 1");
    end

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                changed_q;
    digits_t             digits_q, digits_d;
    logic [3:0]          en_q, en_d;
    logic [3:0]          en_out;
    logic                hold_load;
    logic                hold_zero;
    logic                sel_req;
    digits_t             sel_digits;
    logic [3:0]          sel_en;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANTED;
                    grant_d = highest_req(req);
                end
            end
            GRANTED: begin
                // Once the hold has run out, a higher request or a released owner both re-arbitrate.
                if (hold_zero && ((|(req & higher_mask(grant_q))) || !(|(req & grant_q)))) begin
                    grant_d = highest_req(req);
                    state_d = (|req) ? GRANTED : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    assign hold_load = (grant_d != grant_q) && (grant_d != GNT_NONE);

    always_comb begin
        sel_digits = '0;
        sel_en     = '0;
        unique case (grant_d)
            GNT_ENTRY: begin sel_digits = digits_t'(req_0_digits); sel_en = req_0_en; end
            GNT_COUNT: begin sel_digits = digits_t'(req_1_digits); sel_en = req_1_en; end
            GNT_ALERT: begin sel_digits = digits_t'(req_2_digits); sel_en = req_2_en; end
            default:   begin sel_digits = '0;                      sel_en = '0;       end
        endcase
    end

    assign sel_req = |(req & grant_d);

    // Data follows the next owner so a switch shows new digits with the new grant; a silent owner freezes.
    always_comb begin
        digits_d = digits_q;
        en_d     = en_q;
        if (grant_d == GNT_NONE) begin
            digits_d = '0;
            en_d     = '0;
        end else if (sel_req) begin
            digits_d = sel_digits;
            en_d     = sel_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GNT_NONE;
            changed_q <= 1'b0;
            digits_q  <= '0;
            en_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            changed_q <= (grant_d != grant_q);
            digits_q  <= digits_d;
            en_q      <= en_d;
        end
    end

    tick_down_counter #(
        .WIDTH (HOLD_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (HOLD_W'(MIN_HOLD_TICKS)),
        .tick       (tick_ms),
        .zero       (hold_zero)
    );

`ifdef DISPLAY_ARB_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;

    logic phase_q;
    logic blink_enter;
    logic blink_wrap;
    logic blink_zero;

    // Counter runs HALF-1 .. 0; the tick seen at zero toggles and reloads, giving HALF ticks per phase.
    assign blink_enter = (grant_d == GNT_ALERT) && (grant_q != GNT_ALERT);
    assign blink_wrap  = tick_ms && (grant_q == GNT_ALERT) && blink_zero;

    tick_down_counter #(
        .WIDTH (BLINK_W)
    ) u_blink_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (blink_enter || blink_wrap),
        .load_value (BLINK_W'(BLINK_HALF_TICKS - 1)),
        .tick       (tick_ms && (grant_q == GNT_ALERT)),
        .zero       (blink_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b1;
        end else if (blink_enter) begin
            phase_q <= 1'b1;
        end else if (blink_wrap) begin
            phase_q <= ~phase_q;
        end
    end

    assign en_out = en_q & {4{phase_q || (grant_q != GNT_ALERT)}};
`else
    assign en_out = en_q;
`endif

    assign grant         = grant_q;
    assign grant_changed = changed_q;
    assign digit_3       = digits_q[3];
    assign digit_2       = digits_q[2];
    assign digit_1       = digits_q[1];
    assign digit_0       = digits_q[0];
    assign enable_3      = en_out[3];
    assign enable_2      = en_out[2];
    assign enable_1      = en_out[1];
    assign enable_0      = en_out[0];

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between three requesters: keypad entry (req 0), running countdown (req 1) and expiry alert (req 2).
- Fixed-priority arbitration with a minimum hold time, so short-lived requests cannot make the display flicker.
- Sits between the control logic and the display scanner, in the clk_logic domain.
- Drives the scanner's digit_3..digit_0 and enable_3..enable_0 inputs.

Parameters:
MIN_HOLD_TICKS, 500, tick_ms strobes a grant must last before it can be preempted or released (0 = no hold)
BLINK_HALF_TICKS, 250, tick_ms strobes per blink half-period for req 2 (used only with the optional feature)

Ports:
clk  in  1  logic clock
rst  in  1  synchronous, active-high reset
tick_ms  in  1  single-cycle timing strobe
req  in  3  request lines; bit 2 has highest priority
req_0_digits  in  16  four BCD digits, [15:12] = digit_3
req_1_digits  in  16  as above
req_2_digits  in  16  as above
req_0_en  in  4  per-digit enables, [3] = digit_3
req_1_en  in  4  as above
req_2_en  in  4  as above
grant  out  3  one-hot current owner; 000 = idle
grant_changed  out  1  one-cycle pulse when grant changes
digit_3, digit_2, digit_1, digit_0  out  4 each  to display scanner
enable_3, enable_2, enable_1, enable_0  out  1 each  to display scanner

Behaviour:
- Clocking: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: grant=000, grant_changed=0, all digits=0, all enables=0, hold_cnt=0, blink phase=on, state=IDLE.
- States: IDLE, GRANTED.
- IDLE:
  - Outputs hold zeros/disabled.
  - If any req bit is set, the next cycle enters GRANTED, grant = highest set bit, hold_cnt = MIN_HOLD_TICKS, grant_changed=1.
  - Latency from req to grant is 1 cycle.
- GRANTED, output path:
  - While the owner's req is high, digits/enables register the owner's buses every cycle (1-cycle latency).
  - When the owner's req is low, the last latched values are frozen.
- GRANTED, hold counter:
  - hold_cnt decrements on tick_ms while nonzero.
  - hold_expired = (hold_cnt==0), evaluated on the registered value. A decrement to 0 therefore enables switching one cycle later.
- GRANTED, while hold_expired:
  - Owner req low, other req pending: switch to the highest pending req.
  - Owner req low, none pending: go to IDLE; outputs clear next cycle.
  - Higher-priority req high: preempt it, even if the owner's req is still high.
  - Lower-priority req never preempts.
- GRANTED, while hold not expired: grant is frozen, including against a higher-priority req.
- On every switch:
  - hold_cnt reloads to MIN_HOLD_TICKS.
  - grant_changed pulses for 1 cycle.
  - The new owner's data appears in the same cycle as the new grant.
- Simultaneous requests: the highest index wins. A request that rises and falls while blocked is dropped; there is no queueing.
- MIN_HOLD_TICKS=0: behaves as a pure registered priority mux with 1-cycle switching.
- Digit values are passed through unchecked; values >9 are not altered.
- rst mid-grant returns everything to reset values on the next edge, regardless of tick_ms.

Optional Feature:
- DISPLAY_ARB_BLINK_EN defined:
  - While grant=100, enable outputs are ANDed with a blink phase.
  - The phase toggles every BLINK_HALF_TICKS tick_ms strobes.
  - The phase is forced to "on" and its counter reloaded on each grant to req 2.
  - Other owners are unaffected.
- Not defined: no blink logic; enables pass through unmodified; BLINK_HALF_TICKS is unused.

Decomposition:
- Package disp_arb_pkg:
  - NUM_REQ=3.
  - One-hot grant constants GNT_NONE/GNT_ENTRY/GNT_COUNT/GNT_ALERT.
  - State enum {IDLE, GRANTED}.
  - Digit-bus typedef (4 x 4-bit).
- Sub-module tick_down_counter: loadable down-counter with strobe enable and zero flag. It is instantiated for the hold counter and, under DISPLAY_ARB_BLINK_EN, for the blink counter.

Test Plan (MIN_HOLD_TICKS=4, BLINK_HALF_TICKS=2, tick_ms every 3rd cycle):
- rst held, all req=111 -> grant=000, enables=0000; first cycle after release -> grant=100, digits = req_2_digits, grant_changed=1 for exactly 1 cycle.
- req=001 with digits 0x1234 and en 1111 -> next cycle grant=001, digits 1,2,3,4.
- Then req=011 at once -> grant stays 001 until 4 ticks expire, then switches to 010 one cycle later.
- Owner drops after 1 tick (req=000) -> outputs frozen at last value until hold expires, then grant=000 and enables 0000 on the following cycle.
- Owner 010 expired and held high, req 0 rises -> no preemption; req 2 rises -> grant=100 next cycle, hold reloaded to 4.
- rst asserted mid-GRANTED with hold_cnt=3 -> all outputs at reset values on the next edge; re-grant 1 cycle after rst drops.
- With DISPLAY_ARB_BLINK_EN, grant=100, en 1111 -> enables toggle 1111/0000 every 2 ticks, starting 1111 at grant.
- Without DISPLAY_ARB_BLINK_EN, same stimulus -> enables steady 1111.
